// File: rtl/frame_burst_gen_pkg.sv
// Shared constants for the frame writer family: FSM encoding, legal pixel
// sizes and buffer-count constants used by the buffer selector.
package frame_burst_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int PIXEL_BYTES_1 = 1;
    localparam int PIXEL_BYTES_2 = 2;
    localparam int PIXEL_BYTES_4 = 4;

    localparam int SEL_NUM_BUFFERS = 3;

    // Byte count is formed by shifting, so only power-of-two pixel sizes apply.
    function automatic int pixel_shift(input int pixel_bytes);
        case (pixel_bytes)
            PIXEL_BYTES_4: return 2;
            PIXEL_BYTES_2: return 1;
            default:       return 0;
        endcase
    endfunction

endpackage

// File: rtl/frame_burst_stat.sv
// Bank of saturating event counters; one counter per bit of inc.
module frame_burst_stat #(
    parameter int C_NUM   = 2,
    parameter int C_WIDTH = 32
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [C_NUM-1:0]                inc,
    output logic [C_NUM-1:0][C_WIDTH-1:0]   count
);

    generate
        for (genvar gi = 0; gi < C_NUM; gi++) begin : g_cnt
            logic [C_WIDTH-1:0] count_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    count_reg <= '0;
                end else if (inc[gi] && (count_reg != {C_WIDTH{1'b1}})) begin
                    count_reg <= count_reg + {{(C_WIDTH-1){1'b0}}, 1'b1};
                end
            end

            assign count[gi] = count_reg;
        end
    endgenerate

endmodule

// File: rtl/frame_burst_gen.sv
// Per-frame S2MM command generator: one write command per image line.
// Optional statistics counters are enabled with FRAME_BURST_GEN_STAT_EN.
module frame_burst_gen
    import frame_burst_gen_pkg::*;
#(
    parameter int C_ADDR_WIDTH  = 32,
    parameter int C_IMG_WBITS   = 12,
    parameter int C_IMG_HBITS   = 12,
    parameter int C_PIXEL_BYTES = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      sof,
    input  logic [C_ADDR_WIDTH-1:0]   base_addr,
    input  logic [C_IMG_WBITS-1:0]    img_width,
    input  logic [C_IMG_HBITS-1:0]    img_height,
    input  logic [C_ADDR_WIDTH-1:0]   line_stride,
    output logic                      cmd_valid,
    input  logic                      cmd_ready,
    output logic [C_ADDR_WIDTH-1:0]   cmd_addr,
    output logic [C_IMG_WBITS+1:0]    cmd_bytes,
`ifdef FRAME_BURST_GEN_STAT_EN
    output logic [31:0]               stat_frames,
    output logic [31:0]               stat_overruns,
`endif
    output logic                      cmd_last,
    output logic                      busy,
    output logic                      frame_done,
    output logic                      overrun
);

    localparam int PB_SHIFT = pixel_shift(C_PIXEL_BYTES);

    state_t                    state_reg, state_next;
    logic                      pend_reg, pend_next;
    logic [C_IMG_HBITS-1:0]    line_reg;
    logic [C_IMG_HBITS-1:0]    height_reg;
    logic [C_ADDR_WIDTH-1:0]   stride_reg;
    logic [C_ADDR_WIDTH-1:0]   cmd_addr_reg;
    logic [C_IMG_WBITS+1:0]    cmd_bytes_reg;
    logic [C_IMG_WBITS+1:0]    bytes_load;
    logic                      last_line;
    logic                      handshake;

    assign bytes_load = {2'b00, img_width} << PB_SHIFT;
    assign last_line  = (state_reg == ST_ISSUE) &&
                        (line_reg == height_reg - {{(C_IMG_HBITS-1){1'b0}}, 1'b1});
    assign handshake  = (state_reg == ST_ISSUE) && cmd_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            pend_reg      <= 1'b0;
            line_reg      <= '0;
            height_reg    <= '0;
            stride_reg    <= '0;
            cmd_addr_reg  <= '0;
            cmd_bytes_reg <= '0;
        end else begin
            state_reg <= state_next;
            pend_reg  <= pend_next;
            // Inputs are taken one cycle after sof, once the selector has moved w_addr.
            if (state_reg == ST_LOAD) begin
                cmd_addr_reg  <= base_addr;
                cmd_bytes_reg <= bytes_load;
                height_reg    <= img_height;
                stride_reg    <= line_stride;
                line_reg      <= '0;
            end else if (handshake && !last_line) begin
                cmd_addr_reg <= cmd_addr_reg + stride_reg;
                line_reg     <= line_reg + {{(C_IMG_HBITS-1){1'b0}}, 1'b1};
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        pend_next  = pend_reg;
        case (state_reg)
            ST_IDLE: begin
                if (sof) state_next = ST_LOAD;
            end
            ST_LOAD: begin
                if (sof) pend_next = 1'b1;
                if ((img_width == '0) || (img_height == '0)) state_next = ST_DONE;
                else                                         state_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (sof) pend_next = 1'b1;
                // A pending frame preempts the rest of this one at the next accept.
                if (handshake) begin
                    if (pend_reg || sof) begin
                        state_next = ST_LOAD;
                        pend_next  = 1'b0;
                    end else if (last_line) begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (pend_reg || sof) begin
                    state_next = ST_LOAD;
                    pend_next  = 1'b0;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_valid  = (state_reg == ST_ISSUE);
        busy       = (state_reg == ST_LOAD) || (state_reg == ST_ISSUE);
        frame_done = (state_reg == ST_DONE);
        overrun    = sof && ((state_reg == ST_LOAD) || (state_reg == ST_ISSUE));
        cmd_last   = last_line;
    end

    assign cmd_addr  = cmd_addr_reg;
    assign cmd_bytes = cmd_bytes_reg;

`ifdef FRAME_BURST_GEN_STAT_EN
    logic [1:0][31:0] stat_count;

    frame_burst_stat #(
        .C_NUM   (2),
        .C_WIDTH (32)
    ) u_stat (
        .clk   (clk),
        .reset (reset),
        .inc   ({overrun, frame_done}),
        .count (stat_count)
    );

    assign stat_frames   = stat_count[0];
    assign stat_overruns = stat_count[1];
`endif

endmodule
